// File: rtl/op_seq_pkg.sv
// Shared definitions for the LogicCore9 operand issue sequencer.
package op_seq_pkg;

    localparam int DEFAULT_W       = 8;
    localparam int DEFAULT_TIMEOUT = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/op_issue_sequencer_if.sv
// Operand-in, core-side and result-out signal bundle of the issue sequencer.
interface op_issue_sequencer_if
    import op_seq_pkg::*;
#(
    parameter int W = DEFAULT_W
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [W-1:0] core_a;
    logic [W-1:0] core_b;
    logic         core_start;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_timeout;

    // Sequencer view
    modport master (
        input  in_valid, in_a, in_b, core_done, core_result, out_ready,
        output in_ready, core_a, core_b, core_start, out_valid, out_result, out_timeout
    );

    // Producer / core / consumer view
    modport slave (
        output in_valid, in_a, in_b, core_done, core_result, out_ready,
        input  in_ready, core_a, core_b, core_start, out_valid, out_result, out_timeout
    );
endinterface

// File: rtl/op_watchdog.sv
// Cycle counter that flags when a WAIT has lasted TIMEOUT cycles.
module op_watchdog #(
    parameter  int TIMEOUT = 32,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [CW-1:0] count_r;

    // Count register: clear has priority over enable
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == CW'(TIMEOUT - 1));
endmodule

// File: rtl/op_issue_sequencer.sv
// Issue stage: latches an operand pair, starts the core, collects its result
// (or a watchdog abort) and hands it downstream over valid/ready.
module op_issue_sequencer
    import op_seq_pkg::*;
#(
    parameter int W       = DEFAULT_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    op_issue_sequencer_if.master bus,
    output logic                 busy
);
    state_t       state_r;
    state_t       next_state_s;
    logic         in_ready_r;
    logic         core_start_r;
    logic         busy_r;
    logic [W-1:0] core_a_r;
    logic [W-1:0] core_b_r;
    logic         out_valid_r;
    logic [W-1:0] out_result_r;
    logic         out_timeout_r;
    logic         accept_s;
    logic         capture_s;
    logic         abort_s;
    logic         release_s;
    logic         wd_clear_s;
    logic         wd_enable_s;
    logic         wd_expired_s;

    op_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear_s),
        .enable  (wd_enable_s),
        .expired (wd_expired_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; done beats the watchdog when both arrive together
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) next_state_s = S_START;
                else          next_state_s = S_IDLE;
            end
            S_START: next_state_s = S_WAIT;
            S_WAIT: begin
                if (bus.core_done || wd_expired_s) next_state_s = S_OUT;
                else                               next_state_s = S_WAIT;
            end
            S_OUT: begin
                if (bus.out_ready) next_state_s = S_IDLE;
                else               next_state_s = S_OUT;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        abort_s     = 1'b0;
        release_s   = 1'b0;
        wd_clear_s  = 1'b0;
        wd_enable_s = 1'b0;
        case (state_r)
            S_IDLE:  accept_s   = bus.in_valid & in_ready_r;
            S_START: wd_clear_s = 1'b1;
            S_WAIT: begin
                wd_enable_s = 1'b1;
                if (bus.core_done) begin
                    capture_s = 1'b1;
                end else if (wd_expired_s) begin
                    abort_s = 1'b1;
                end else begin
                    capture_s = 1'b0;
                end
            end
            S_OUT: begin
                if (bus.out_ready) release_s = 1'b1;
                else               release_s = 1'b0;
            end
            default: accept_s = 1'b0;
        endcase
    end

    // Handshake flags are registered from the next state so they stay low through reset
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r   <= 1'b0;
            core_start_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            in_ready_r   <= (next_state_s == S_IDLE);
            core_start_r <= (next_state_s == S_START);
            busy_r       <= (next_state_s != S_IDLE);
        end
    end

    // Operand latch and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            core_a_r      <= {W{1'b0}};
            core_b_r      <= {W{1'b0}};
            out_valid_r   <= 1'b0;
            out_result_r  <= {W{1'b0}};
            out_timeout_r <= 1'b0;
        end else begin
            if (accept_s) begin
                core_a_r <= bus.in_a;
                core_b_r <= bus.in_b;
            end
            if (capture_s) begin
                out_result_r  <= bus.core_result;
                out_timeout_r <= 1'b0;
                out_valid_r   <= 1'b1;
            end else if (abort_s) begin
                out_result_r  <= {W{1'b0}};
                out_timeout_r <= 1'b1;
                out_valid_r   <= 1'b1;
            end else if (release_s) begin
                out_valid_r   <= 1'b0;
            end
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.core_a      = core_a_r;
    assign bus.core_b      = core_b_r;
    assign bus.core_start  = core_start_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_timeout = out_timeout_r;
    assign busy            = busy_r;
endmodule

// File: tb/tb_op_issue_sequencer.sv
// Randomized self-checking bench: a transaction-level model predicts when and
// what the sequencer must deliver for each operand pair and core latency.
module tb_op_issue_sequencer;
    import op_seq_pkg::*;

    localparam int W  = DEFAULT_W;
    localparam int TO = DEFAULT_TIMEOUT;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    op_issue_sequencer_if #(.W(W)) bus ();

    op_issue_sequencer #(.W(W), .TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction. lat = WAIT cycle in which the core raises done;
    // anything beyond TO means the watchdog fires first.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] res, input int hold, input bit done_in_start);
        bit           to;
        int           exit_k;
        logic [W-1:0] exp_res;
        to      = !(lat >= 1 && lat <= TO);
        exit_k  = to ? TO : lat;
        exp_res = to ? {W{1'b0}} : res;

        chk("idle_ready", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        tick();
        bus.in_valid    = 1'($urandom_range(0, 1));
        bus.in_a        = W'($urandom);
        bus.in_b        = W'($urandom);
        bus.core_done   = done_in_start;
        bus.core_result = W'($urandom);
        chk("start_pulse", bus.core_start, 1);
        chk("start_a", bus.core_a, a);
        chk("start_b", bus.core_b, b);
        chk("start_ready", bus.in_ready, 0);
        chk("start_busy", busy, 1);
        chk("start_ovalid", bus.out_valid, 0);
        tick();
        for (int k = 1; k <= exit_k; k++) begin
            bus.core_done   = (k == lat);
            bus.core_result = (k == lat) ? res : W'($urandom);
            chk("wait_start", bus.core_start, 0);
            chk("wait_a", bus.core_a, a);
            chk("wait_b", bus.core_b, b);
            chk("wait_ovalid", bus.out_valid, 0);
            chk("wait_ready", bus.in_ready, 0);
            tick();
        end
        bus.core_done   = 1'($urandom_range(0, 1));
        bus.core_result = W'($urandom);
        chk("out_valid", bus.out_valid, 1);
        chk("out_result", bus.out_result, exp_res);
        chk("out_timeout", bus.out_timeout, to);
        chk("out_ready_in", bus.in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            tick();
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_result", bus.out_result, exp_res);
            chk("bp_timeout", bus.out_timeout, to);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_start", bus.core_start, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.core_done = 1'b0;
        chk("rel_valid", bus.out_valid, 0);
        chk("rel_in_ready", bus.in_ready, 1);
        chk("rel_busy", busy, 0);
        chk("rel_result", bus.out_result, exp_res);
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_a        = 8'hAA;
        bus.in_b        = 8'h55;
        bus.core_done   = 1'b0;
        bus.core_result = 8'h00;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_core_start", bus.core_start, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_result", bus.out_result, 0);
            chk("rst_core_a", bus.core_a, 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", busy, 0);

        run_txn(8'hFD, 8'h02, 5, 8'h09, 0, 1'b0);     // basic
        run_txn(8'h11, 8'h22, 3, 8'h33, 10, 1'b0);    // backpressure
        run_txn(8'h80, 8'h7F, TO + 5, 8'h55, 2, 1'b0); // watchdog abort
        run_txn(8'h01, 8'hFF, TO, 8'h7F, 1, 1'b1);    // done on the last cycle, done in START

        // Spurious done while idle
        for (int i = 0; i < 4; i++) begin
            bus.core_done = 1'b1;
            tick();
            chk("idle_busy", busy, 0);
            chk("idle_in_ready", bus.in_ready, 1);
            chk("idle_ovalid", bus.out_valid, 0);
            chk("idle_start", bus.core_start, 0);
            chk("idle_result", bus.out_result, 8'h7F);
        end
        bus.core_done = 1'b0;

        // Reset three cycles into WAIT
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h5A;
        bus.in_b     = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("midwait_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_in_ready", bus.in_ready, 0);
        chk("mrst_core_a", bus.core_a, 0);
        chk("mrst_core_b", bus.core_b, 0);
        chk("mrst_start", bus.core_start, 0);
        chk("mrst_ovalid", bus.out_valid, 0);
        chk("mrst_result", bus.out_result, 0);
        chk("mrst_timeout", bus.out_timeout, 0);
        chk("mrst_busy", busy, 0);
        tick();
        chk("mrst_ready_after", bus.in_ready, 1);
        run_txn(8'h3C, 8'hC3, 2, 8'hE1, 0, 1'b0);

        for (int t = 0; t < 20; t++) begin
            run_txn(W'($urandom), W'($urandom), int'($urandom_range(1, TO + 4)),
                    W'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
